ic_scr_key_ctrl: RTL and testbench

Scramble key refresh controller for the instruction cache. It sits directly upstream of the icache and its scrambled tag/data RAM banks. It requests a fresh key and nonce from the key source after reset and on every invalidation request, then hands the latched key, the nonce and the combined data-bank nonce to the RAMs. It holds the icache invalidate line until the new key is valid.

---
 rtl/ic_scr_key_ctrl.sv | 111 +++++++++++
 tb/tb_ic_scr_key_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ic_scr_key_ctrl.sv
// Scramble key refresh controller for the icache RAM banks: fetches a new key/nonce after reset
// and on every invalidate request. Optional ack-wait timeout is built when IC_SCR_KEY_TIMEOUT_EN is defined.
module ic_scr_key_ctrl #(
  parameter int unsigned KeyW          = 128,
  parameter int unsigned NonceW        = 64,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  inval_req_i,
  output logic                  key_req_o,
  input  logic                  key_ack_i,
  input  logic [KeyW-1:0]       key_i,
  input  logic [NonceW-1:0]     nonce_i,
  output logic [KeyW-1:0]       key_o,
  output logic [NonceW-1:0]     nonce_o,
  output logic [2*NonceW-1:0]   nonce_buf_o,
  output logic                  key_valid_o,
  output logic                  icache_inval_o,
  output logic                  busy_o,
  output logic                  timeout_o
);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2,
    IDLE  = 2'd3
  } state_e;

  state_e r_state;
  state_e w_state_nxt;
  logic   w_ack_accept;

  logic [KeyW-1:0]     r_key;
  logic [NonceW-1:0]   r_nonce;
  logic [2*NonceW-1:0] r_nonce_buf;

  // An ack is only meaningful while a request is outstanding.
  assign w_ack_accept = (r_state == REQ) && key_ack_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Requests seen in INIT or REQ need no action: the refresh in flight covers them.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      INIT:    w_state_nxt = REQ;
      REQ:     if (key_ack_i) w_state_nxt = VALID;
      VALID:   w_state_nxt = inval_req_i ? REQ : IDLE;
      IDLE:    if (inval_req_i) w_state_nxt = REQ;
      default: w_state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_key       <= '0;
      r_nonce     <= '0;
      r_nonce_buf <= '0;
    end else if (w_ack_accept) begin
      r_key       <= key_i;
      r_nonce     <= nonce_i;
      r_nonce_buf <= {r_nonce, nonce_i};
    end
  end

  assign key_o          = r_key;
  assign nonce_o        = r_nonce;
  assign nonce_buf_o    = r_nonce_buf;
  assign key_req_o      = (r_state == REQ);
  assign key_valid_o    = (r_state == VALID);
  assign icache_inval_o = (r_state == REQ) || (r_state == VALID);
  assign busy_o         = (r_state == REQ) || (r_state == VALID);

`ifdef IC_SCR_KEY_TIMEOUT_EN
  logic [15:0] r_to_cnt;
  logic        r_timeout;

  // Counter sits at zero outside REQ, so it restarts on every entry to REQ.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      if ((r_state != REQ) || key_ack_i) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt + 16'd1 == 16'(TimeoutCycles)) begin
        r_to_cnt  <= '0;
        r_timeout <= 1'b1;
      end else begin
        r_to_cnt <= r_to_cnt + 16'd1;
      end
    end
  end

  assign timeout_o = r_timeout;
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = |16'(TimeoutCycles);
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_ic_scr_key_ctrl.sv
// Bench for ic_scr_key_ctrl: directed refresh scenarios plus a randomized phase; installed keys are
// checked by a key_valid_o-driven monitor against an expected queue filled by the ack driver.
`timescale 1ns/1ps
module tb_ic_scr_key_ctrl;
  localparam int KeyW          = 128;
  localparam int NonceW        = 64;
  localparam int TimeoutCycles = 4;
  localparam int EW            = KeyW + 3 * NonceW;

  // Handshake: key_req_o high means a request is open; one cycle of key_ack_i while it is high
  // delivers key_i/nonce_i, and key_valid_o with the new key follows on the next cycle.

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                inval_req = 1'b0;
  logic                key_ack = 1'b0;
  logic [KeyW-1:0]     key_in = '0;
  logic [NonceW-1:0]   nonce_in = '0;
  logic                key_req_o;
  logic [KeyW-1:0]     key_o;
  logic [NonceW-1:0]   nonce_o;
  logic [2*NonceW-1:0] nonce_buf_o;
  logic                key_valid_o;
  logic                icache_inval_o;
  logic                busy_o;
  logic                timeout_o;

  int vectors = 0;
  int miscompares = 0;
  int valid_seen = 0;

  logic [EW-1:0]     exp_q[$];
  logic [EW-1:0]     mon_e;
  logic [KeyW-1:0]   model_key = '0;
  logic [NonceW-1:0] model_nonce = '0;

  localparam logic [KeyW-1:0]   SpecKey   = 128'h14e8cecae3040d5e12286bb3cc113298;
  localparam logic [NonceW-1:0] SpecNonce = 64'hf79780bc735f3843;

  always #5 clk = ~clk;

  ic_scr_key_ctrl #(
    .KeyW(KeyW), .NonceW(NonceW), .TimeoutCycles(TimeoutCycles)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .inval_req_i(inval_req),
    .key_req_o(key_req_o), .key_ack_i(key_ack), .key_i(key_in), .nonce_i(nonce_in),
    .key_o(key_o), .nonce_o(nonce_o), .nonce_buf_o(nonce_buf_o),
    .key_valid_o(key_valid_o), .icache_inval_o(icache_inval_o),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  task automatic check_val(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  function automatic logic [KeyW-1:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [NonceW-1:0] rand_nonce();
    return {$urandom, $urandom};
  endfunction

  // Advance to the next sampling point; the ack is a one-cycle pulse unless re-driven.
  task automatic tick();
    @(negedge clk);
    key_ack = 1'b0;
  endtask

  // Ack an open request: the model records the key it expects to see installed.
  task automatic give_ack(input logic [KeyW-1:0] k, input logic [NonceW-1:0] n);
    key_ack  = 1'b1;
    key_in   = k;
    nonce_in = n;
    exp_q.push_back({k, n, model_nonce, n});
    model_nonce = n;
    model_key   = k;
  endtask

  task automatic spurious_ack(input logic [KeyW-1:0] k, input logic [NonceW-1:0] n);
    key_ack  = 1'b1;
    key_in   = k;
    nonce_in = n;
  endtask

  task automatic model_reset();
    exp_q.delete();
    model_key   = '0;
    model_nonce = '0;
  endtask

  always @(negedge clk) begin
    if (rst_n && key_valid_o) begin
      valid_seen++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_key_valid: got pulse with key %0h, expected none", key_o);
      end else begin
        mon_e = exp_q.pop_front();
        check_val("mon_key_o", EW'(key_o), EW'(mon_e[EW-1 -: KeyW]));
        check_val("mon_nonce_o", EW'(nonce_o), EW'(mon_e[2*NonceW +: NonceW]));
        check_val("mon_nonce_buf_o", EW'(nonce_buf_o), EW'(mon_e[2*NonceW-1:0]));
        check_bit("mon_inval_with_valid", icache_inval_o, 1'b1);
        check_bit("mon_no_req_with_valid", key_req_o, 1'b0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int inval_cnt;
    int v0;
    logic drained;
    logic [KeyW-1:0] k_hold;

    // Reset values
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_bit("rst_key_req", key_req_o, 1'b0);
    check_bit("rst_key_valid", key_valid_o, 1'b0);
    check_bit("rst_inval", icache_inval_o, 1'b0);
    check_bit("rst_busy", busy_o, 1'b0);
    check_bit("rst_timeout", timeout_o, 1'b0);
    check_val("rst_key_o", EW'(key_o), '0);
    check_val("rst_nonce_o", EW'(nonce_o), '0);
    check_val("rst_nonce_buf", EW'(nonce_buf_o), '0);

    // First refresh after reset, ack in the 3rd REQ cycle
    rst_n = 1'b1;
    inval_cnt = 0;
    check_bit("init_no_req", key_req_o, 1'b0);
    tick();
    check_bit("req_after_reset", key_req_o, 1'b1);
    if (icache_inval_o) inval_cnt++;
    tick();
    if (icache_inval_o) inval_cnt++;
    tick();
    if (icache_inval_o) inval_cnt++;
    give_ack(SpecKey, SpecNonce);
    tick();
    if (icache_inval_o) inval_cnt++;
    check_bit("first_valid", key_valid_o, 1'b1);
    check_val("first_key_o", EW'(key_o), EW'(SpecKey));
    check_val("first_nonce_buf", EW'(nonce_buf_o), EW'({64'h0, SpecNonce}));
    tick();
    if (icache_inval_o) inval_cnt++;
    check_bit("first_valid_one_pulse", key_valid_o, 1'b0);
    check_bit("first_idle_busy", busy_o, 1'b0);
    check_val("first_inval_cycles", EW'(inval_cnt), EW'(4));

    // Second refresh from IDLE, minimum latency
    inval_req = 1'b1;
    tick();
    inval_req = 1'b0;
    check_bit("second_req", key_req_o, 1'b1);
    give_ack(rand_key(), 64'h1);
    tick();
    check_bit("second_valid", key_valid_o, 1'b1);
    check_val("second_nonce_buf", EW'(nonce_buf_o), EW'({SpecNonce, 64'h1}));
    tick();
    check_bit("second_idle_after_3", busy_o, 1'b0);

    // Ack while idle is ignored
    k_hold = model_key;
    spurious_ack({KeyW{1'b1}}, {NonceW{1'b1}});
    tick();
    check_bit("idle_ack_busy", busy_o, 1'b0);
    check_val("idle_ack_key", EW'(key_o), EW'(k_hold));
    tick();
    check_bit("idle_ack_no_valid", key_valid_o, 1'b0);
    check_val("idle_ack_buf", EW'(nonce_buf_o), EW'({SpecNonce, 64'h1}));

    // Request held high across VALID re-enters REQ
    v0 = valid_seen;
    inval_req = 1'b1;
    tick();
    give_ack(rand_key(), rand_nonce());
    tick();
    check_bit("held_valid1", key_valid_o, 1'b1);
    tick();
    check_bit("held_reenter_req", key_req_o, 1'b1);
    give_ack(rand_key(), rand_nonce());
    tick();
    inval_req = 1'b0;
    check_bit("held_valid2", key_valid_o, 1'b1);
    tick();
    check_bit("held_idle", busy_o, 1'b0);
    check_val("held_two_pulses", EW'(valid_seen - v0), EW'(2));

    // Request during REQ is absorbed
    inval_req = 1'b1;
    tick();
    tick();
    check_bit("absorb_still_req", key_req_o, 1'b1);
    inval_req = 1'b0;
    give_ack(rand_key(), rand_nonce());
    tick();
    tick();
    check_bit("absorb_no_second", busy_o, 1'b0);

`ifdef IC_SCR_KEY_TIMEOUT_EN
    // No ack for 10 REQ cycles; a pulse follows every 4th unacknowledged cycle
    inval_req = 1'b1;
    tick();
    inval_req = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      check_bit("to_key_req_held", key_req_o, 1'b1);
      check_bit("to_pulse", timeout_o, (c == 5) || (c == 9));
      tick();
    end
    give_ack(rand_key(), rand_nonce());
    tick();
    tick();
`endif

    // Randomized phase
    for (int i = 0; i < 400; i++) begin
      tick();
      check_val("rand_key_hold", EW'(key_o), EW'(model_key));
`ifndef IC_SCR_KEY_TIMEOUT_EN
      check_bit("rand_timeout_tied", timeout_o, 1'b0);
`endif
      inval_req = ($urandom_range(0, 3) == 0);
      if (key_req_o) begin
        if ($urandom_range(0, 2) == 0) give_ack(rand_key(), rand_nonce());
      end else if ($urandom_range(0, 7) == 0) begin
        spurious_ack(rand_key(), rand_nonce());
      end
    end

    inval_req = 1'b0;
    drained = 1'b0;
    for (int i = 0; i < 50 && !drained; i++) begin
      tick();
      if (key_req_o) give_ack(rand_key(), rand_nonce());
      else if (!busy_o) drained = 1'b1;
    end
    check_bit("rand_drained", drained, 1'b1);

    // Asynchronous reset in the middle of a refresh
    inval_req = 1'b1;
    tick();
    inval_req = 1'b0;
    check_bit("rstmid_in_req", key_req_o, 1'b1);
    rst_n = 1'b0;
    #1;
    check_val("rstmid_key_cleared", EW'(key_o), '0);
    check_bit("rstmid_req_low", key_req_o, 1'b0);
    check_val("rstmid_buf_cleared", EW'(nonce_buf_o), '0);
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    check_bit("rstmid_init", key_req_o, 1'b0);
    tick();
    check_bit("rstmid_req_again", key_req_o, 1'b1);
    give_ack(rand_key(), SpecNonce);
    tick();
    check_val("rstmid_buf_fresh", EW'(nonce_buf_o), EW'({64'h0, SpecNonce}));
    tick();
    tick();

    check_val("queue_empty", EW'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
